scan_7s_ctrl: RTL and testbench
===============================

// Module: scan_7s_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an NUM_DIGITS-digit 7-segment display sharing one bcd7s decoder.
//  Latches a packed BCD word, selects one digit at a time, feeds its code to the shared decoder and
//  drives the matching anode, with a blanking guard between digits against ghosting.
//  Sits between the application datapath (counters, ALU results) and the board display pins.
// PARAMETERS
//  NUM_DIGITS    4      digits scanned, 2..8
//  DWELL_CYCLES  50000  clk cycles per digit slot (blank + lit), >= BLANK_CYCLES+2
//  BLANK_CYCLES  500    cycles at start of each slot with all anodes off, >= 1
// PORTS
//  clk        in   1             system clock, rising edge
//  rst        in   1             synchronous reset, active-high
//  en         in   1             1 = scanning; 0 = display dark (an all 1s)
//  load       in   1             1-cycle strobe: capture bcd_in/dp_in into shadow register
//  bcd_in     in   4*NUM_DIGITS  packed BCD, digit 0 (rightmost) in [3:0]
//  dp_in      in   NUM_DIGITS    decimal point per digit, 1 = lit
//  lz_supp    in   1             1 = blank leading zeros (digit 0 never blanked)
//  an         out  NUM_DIGITS    anode enables, active-low, one-hot-low while lit
//  seg        out  7             segments gfedcba, active-high, from bcd7s
//  dp         out  1             decimal point of active digit, active-high
//  frame_done out  1             1-cycle pulse when last digit's slot ends
// BEHAVIOUR
//  Reset: an=all 1s, dp=0, frame_done=0, state=IDLE, digit idx=0, slot counter=0, shadow & active regs=0,
//   load_pend=0; seg = decoder of 0 (7'b0111111) but anodes off so nothing lit.
//  Double buffer: load copies bcd_in/dp_in to shadow and sets load_pend; shadow -> active only at frame
//   boundary (idx wraps to 0) or on IDLE->BLANK; load_pend cleared that cycle. load while load_pend=1
//   overwrites shadow (last write wins). load same cycle as boundary: new data goes to shadow, old shadow
//   transfers, load_pend stays 1.
//  FSM states: IDLE, BLANK, LIT.
//   IDLE : an all 1s. en=1 -> BLANK, idx=0, counter=0, shadow->active.
//   BLANK: an all 1s; cur_code register loads active digit idx. counter==BLANK_CYCLES-1 -> LIT.
//   LIT  : an[idx]=0 unless digit suppressed; counter==DWELL_CYCLES-1 -> BLANK, counter=0,
//          idx=idx+1 (wrap NUM_DIGITS-1 -> 0, frame_done=1 that cycle).
//   en=0 in any state -> IDLE next cycle, an all 1s next cycle; idx reset to 0.
//  Counter: width $clog2(DWELL_CYCLES), counts 0..DWELL_CYCLES-1 across the slot, never overflows.
//  Timing: an, dp, cur_code are registered and change on the same edge; seg = bcd7s(cur_code) combinational
//   from cur_code, so seg/an are aligned with zero skew in cycles. One full frame = NUM_DIGITS*DWELL_CYCLES.
//  Leading-zero suppression (lz_supp=1): digit k blanked (an[k] held 1 during LIT) iff k>0 and all active
//   digits k..NUM_DIGITS-1 equal 0. Evaluated on active register, not shadow.
//  Codes 10..15 passed unchanged to decoder (it renders them as "0"); no error flag.
//  dp = active_dp[idx] during LIT when digit not suppressed, else 0.
//  rst mid-slot: all outputs return to reset values next edge; pending load discarded.
// STRUCTURE
//  Shared package: state encoding constants (IDLE=2'd0, BLANK=2'd1, LIT=2'd2), segment-off constant.
//  One sub-module: bcd7s instance (u_dec) driven by cur_code; no other hierarchy.
//  Leading-zero mask: combinational per-digit OR-chain over active register.
// TESTING  (sim params NUM_DIGITS=4, DWELL_CYCLES=8, BLANK_CYCLES=2)
//  1 rst held 3 cycles, en=1 -> an=4'b1111 through reset; first LIT at cycle 3 after rst drop, an=4'b1110.
//  2 load bcd_in=16'h1234, en=1 -> digit order 4,3,2,1 on seg (1100110,1001111,1011011,0000110), each lit 6
//    cycles after 2 blank; frame_done pulses every 32 cycles.
//  3 lz_supp=1, bcd_in=16'h0050 -> an[3],an[2] never 0; digit1 shows 5, digit0 shows 0 (0111111).
//  4 load 16'h1111 mid-frame at digit 2 -> digits 2,3 still show old value; new value from next frame start.
//  5 en dropped during LIT of digit 1 -> an=4'b1111 next cycle; en re-raised -> restart at digit 0 BLANK.
//  6 dp_in=4'b0100, bcd_in=16'h9999 -> dp=1 only while an=4'b1011; seg=1101111 on all digits.

Source files
------------

// File: rtl/scan_7s_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM states and segment constants.
package scan_7s_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        LIT   = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

endpackage

// File: rtl/scan_7s_ctrl_bcd7s.sv
// BCD to 7-segment decoder (gfedcba, active-high); codes 10..15 render as "0".
module bcd7s
    import scan_7s_ctrl_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (code)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b0111111;
        endcase
    end

endmodule

// File: rtl/scan_7s_ctrl.sv
// Time-multiplexed scan controller for a NUM_DIGITS-digit 7-segment display with a
// double-buffered digit register, per-slot blanking guard and leading-zero suppression.
module scan_7s_ctrl
    import scan_7s_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_supp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SLOT_END  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(NUM_DIGITS - 1);

    scan_state_t state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             boundary, wrap;

    logic [4*NUM_DIGITS-1:0] shadow_bcd, active_bcd;
    logic [NUM_DIGITS-1:0]   shadow_dp, active_dp;
    logic                    load_pend;

    logic [3:0]            cur_code, code_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic                  dp_nxt;
    logic                  frame_nxt;

    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  nz_seen;
    logic [3:0]            sel_digit;
    logic                  sel_dp, sel_blank;

    // Walk from the most significant digit down; a digit is blanked until a nonzero one is seen.
    always_comb begin
        nz_seen = 1'b0;
        lz_mask = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            nz_seen = nz_seen | (active_bcd[(NUM_DIGITS-1-i)*4 +: 4] != 4'd0);
            lz_mask[NUM_DIGITS-1-i] = lz_supp & ~nz_seen & (i != NUM_DIGITS - 1);
        end
    end

    always_comb begin
        sel_digit = '0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                sel_digit = active_bcd[k*4 +: 4];
                sel_dp    = active_dp[k];
                sel_blank = lz_mask[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            cur_code   <= '0;
            an         <= '1;
            dp         <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            cur_code   <= code_nxt;
            an         <= an_nxt;
            dp         <= dp_nxt;
            frame_done <= frame_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        boundary  = 1'b0;
        wrap      = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    boundary  = 1'b1;
                end
                BLANK: begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == CNT_BLANK_END) state_nxt = LIT;
                end
                LIT: begin
                    if (cnt == CNT_SLOT_END) begin
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                        if (idx == IDX_LAST) begin
                            idx_nxt  = '0;
                            wrap     = 1'b1;
                            boundary = 1'b1;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // cur_code follows the selected digit throughout BLANK, so it already holds
    // the right code on the edge where the anode turns on.
    always_comb begin
        an_nxt    = '1;
        dp_nxt    = 1'b0;
        frame_nxt = wrap;
        code_nxt  = (state == BLANK) ? sel_digit : cur_code;
        if (state_nxt == LIT && !sel_blank) begin
            dp_nxt = sel_dp;
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                if (idx == IDX_W'(k)) an_nxt[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_bcd <= '0;
            shadow_dp  <= '0;
            active_bcd <= '0;
            active_dp  <= '0;
            load_pend  <= 1'b0;
        end else begin
            if (load) begin
                shadow_bcd <= bcd_in;
                shadow_dp  <= dp_in;
            end
            if (boundary && load_pend) begin
                active_bcd <= shadow_bcd;
                active_dp  <= shadow_dp;
            end
            if (load)          load_pend <= 1'b1;
            else if (boundary) load_pend <= 1'b0;
        end
    end

    bcd7s u_dec (
        .code (cur_code),
        .seg  (seg)
    );

endmodule

// File: tb/tb_scan_7s_ctrl.sv
// Randomized and directed bench for scan_7s_ctrl against a timeline-based display model.
module tb_scan_7s_ctrl;

    localparam int unsigned ND    = 4;
    localparam int unsigned DWELL = 8;
    localparam int unsigned BLANK = 2;
    localparam int unsigned FRAME = ND * DWELL;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        lz_supp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int unsigned n_vec;
    int unsigned n_err;

    // Model: position p counts cycles since scanning began; the frame data is
    // whatever was in the shadow when the frame started.
    logic [15:0] m_shadow, m_active;
    logic [3:0]  m_shadow_dp, m_active_dp;
    bit          m_scan;
    int unsigned m_p;
    logic [3:0]  exp_an;
    logic        exp_dp, exp_fd, exp_lit;
    logic [6:0]  exp_seg;

    scan_7s_ctrl #(
        .NUM_DIGITS   (ND),
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .lz_supp    (lz_supp),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] dec_ref(input logic [3:0] c);
        case (c)
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic tick();
        int unsigned d;
        @(posedge clk);
        if (rst) begin
            m_scan = 0; m_p = 0;
            m_shadow = '0; m_shadow_dp = '0;
            m_active = '0; m_active_dp = '0;
        end else begin
            if (!en) begin
                m_scan = 0;
            end else if (!m_scan) begin
                m_scan = 1; m_p = 0;
                m_active = m_shadow; m_active_dp = m_shadow_dp;
            end else begin
                m_p++;
                if (m_p % FRAME == 0) begin
                    m_active = m_shadow; m_active_dp = m_shadow_dp;
                end
            end
            if (load) begin
                m_shadow = bcd_in; m_shadow_dp = dp_in;
            end
        end
        exp_an  = 4'hF;
        exp_dp  = 1'b0;
        exp_lit = 1'b0;
        exp_seg = 7'b0111111;
        exp_fd  = m_scan && m_p != 0 && (m_p % FRAME == 0);
        if (m_scan && (m_p % DWELL) >= BLANK) begin
            d = (m_p / DWELL) % ND;
            if (!(lz_supp && d > 0 && (m_active >> (4 * d)) == 16'd0)) begin
                exp_an[d] = 1'b0;
                exp_dp    = m_active_dp[d];
                exp_lit   = 1'b1;
                exp_seg   = dec_ref(m_active[4*d +: 4]);
            end
        end
        #1;
    endtask

    task automatic start_scan(input logic [15:0] v, input logic [3:0] dpv, input logic lz);
        en = 0; load = 0; lz_supp = lz;
        tick();
        load = 1; bcd_in = v; dp_in = dpv;
        tick();
        load = 0; en = 1;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; load = 0; bcd_in = '0; dp_in = '0; lz_supp = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({an, dp, frame_done, seg} !== {4'hF, 1'b0, 1'b0, 7'b0111111}) begin
                n_err++;
                $display("FAIL reset an/dp/fd/seg=%b/%b/%b/%b expected 1111/0/0/0111111", an, dp, frame_done, seg);
            end
        end
        rst = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            n_vec++;
            if (i < 3 && an !== 4'hF) begin
                n_err++; $display("FAIL reset_blank cycle %0d an=%b expected 1111", i, an);
            end else if (i == 3 && an !== 4'b1110) begin
                n_err++; $display("FAIL first_lit cycle 3 an=%b expected 1110", an);
            end
            n_vec++;
            if ({an, dp, frame_done} !== {exp_an, exp_dp, exp_fd}) begin
                n_err++;
                $display("FAIL reset_model p=%0d an/dp/fd=%b/%b/%b expected %b/%b/%b", m_p, an, dp, frame_done, exp_an, exp_dp, exp_fd);
            end
        end
    endtask

    task automatic test_digit_order();
        int unsigned fd_cnt;
        int          last_fd;
        logic [6:0]  want;
        bit          chk;
        fd_cnt = 0; last_fd = -1;
        start_scan(16'h1234, 4'h0, 0);
        for (int i = 0; i <= 2 * FRAME; i++) begin
            tick();
            n_vec++;
            if ({an, dp, frame_done} !== {exp_an, exp_dp, exp_fd}) begin
                n_err++;
                $display("FAIL order_model p=%0d an/dp/fd=%b/%b/%b expected %b/%b/%b", m_p, an, dp, frame_done, exp_an, exp_dp, exp_fd);
            end
            chk = 1;
            case (an)
                4'b1110: want = 7'b1100110;
                4'b1101: want = 7'b1001111;
                4'b1011: want = 7'b1011011;
                4'b0111: want = 7'b0000110;
                default: begin chk = 0; want = 7'b0; end
            endcase
            if (chk) begin
                n_vec++;
                if (seg !== want) begin
                    n_err++; $display("FAIL order_seg an=%b seg=%b expected %b", an, seg, want);
                end
            end
            if (frame_done === 1'b1) begin
                fd_cnt++;
                if (last_fd >= 0) begin
                    n_vec++;
                    if (i - last_fd != FRAME) begin
                        n_err++; $display("FAIL frame_period got %0d expected %0d", i - last_fd, FRAME);
                    end
                end
                last_fd = i;
            end
        end
        n_vec++;
        if (fd_cnt != 2) begin
            n_err++; $display("FAIL frame_count got %0d expected 2", fd_cnt);
        end
    endtask

    task automatic test_lz();
        start_scan(16'h0050, 4'h0, 1);
        for (int i = 0; i < 40; i++) begin
            tick();
            n_vec++;
            if ((an[3] & an[2]) !== 1'b1) begin
                n_err++; $display("FAIL lz_upper an=%b expected an[3:2]=11", an);
            end
            n_vec++;
            if ({an, dp, frame_done} !== {exp_an, exp_dp, exp_fd}) begin
                n_err++;
                $display("FAIL lz_model p=%0d an/dp/fd=%b/%b/%b expected %b/%b/%b", m_p, an, dp, frame_done, exp_an, exp_dp, exp_fd);
            end
            if (an == 4'b1101 || an == 4'b1110) begin
                n_vec++;
                if (seg !== (an == 4'b1101 ? 7'b1101101 : 7'b0111111)) begin
                    n_err++; $display("FAIL lz_seg an=%b seg=%b", an, seg);
                end
            end
        end
        lz_supp = 0;
    endtask

    task automatic test_midframe_load();
        start_scan(16'h1234, 4'h0, 0);
        for (int i = 0; i < 70; i++) begin
            tick();
            load = (m_p == 17);
            if (m_p == 17) bcd_in = 16'h1111;
            n_vec++;
            if ({an, dp, frame_done} !== {exp_an, exp_dp, exp_fd}) begin
                n_err++;
                $display("FAIL midload_model p=%0d an/dp/fd=%b/%b/%b expected %b/%b/%b", m_p, an, dp, frame_done, exp_an, exp_dp, exp_fd);
            end
            if (m_p < FRAME && an == 4'b1011) begin
                n_vec++;
                if (seg !== 7'b1011011) begin
                    n_err++; $display("FAIL midload_old seg=%b expected 1011011", seg);
                end
            end
            if (m_p >= FRAME && an != 4'hF) begin
                n_vec++;
                if (seg !== 7'b0000110) begin
                    n_err++; $display("FAIL midload_new an=%b seg=%b expected 0000110", an, seg);
                end
            end
        end
        load = 0;
    endtask

    task automatic test_en_drop();
        start_scan(16'h1234, 4'h0, 0);
        for (int i = 0; i < 13; i++) tick();
        en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({an, dp} !== {4'hF, 1'b0}) begin
                n_err++; $display("FAIL en_drop an/dp=%b/%b expected 1111/0", an, dp);
            end
        end
        en = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 3) begin
                n_vec++;
                if ({an, seg} !== {4'b1110, 7'b1100110}) begin
                    n_err++; $display("FAIL en_restart an/seg=%b/%b expected 1110/1100110", an, seg);
                end
            end
            n_vec++;
            if ({an, dp, frame_done} !== {exp_an, exp_dp, exp_fd}) begin
                n_err++;
                $display("FAIL en_model p=%0d an/dp/fd=%b/%b/%b expected %b/%b/%b", m_p, an, dp, frame_done, exp_an, exp_dp, exp_fd);
            end
        end
    endtask

    task automatic test_dp();
        start_scan(16'h9999, 4'b0100, 0);
        for (int i = 0; i < 40; i++) begin
            tick();
            n_vec++;
            if (dp !== (an == 4'b1011)) begin
                n_err++; $display("FAIL dp_digit2 an=%b dp=%b", an, dp);
            end
            if (an != 4'hF) begin
                n_vec++;
                if (seg !== 7'b1101111) begin
                    n_err++; $display("FAIL dp_seg seg=%b expected 1101111", seg);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        start_scan(16'h1234, 4'hF, 0);
        for (int i = 0; i < 21; i++) begin
            tick();
            load = (m_p == 17);
            bcd_in = 16'h9999; dp_in = 4'h0;
        end
        load = 0; rst = 1;
        tick();
        n_vec++;
        if ({an, dp, frame_done, seg} !== {4'hF, 1'b0, 1'b0, 7'b0111111}) begin
            n_err++;
            $display("FAIL rst_mid an/dp/fd/seg=%b/%b/%b/%b expected 1111/0/0/0111111", an, dp, frame_done, seg);
        end
        rst = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_vec++;
            if ({an, dp, frame_done} !== {exp_an, exp_dp, exp_fd}) begin
                n_err++;
                $display("FAIL rst_mid_model p=%0d an/dp/fd=%b/%b/%b expected %b/%b/%b", m_p, an, dp, frame_done, exp_an, exp_dp, exp_fd);
            end
            if (exp_lit) begin
                n_vec++;
                if (seg !== 7'b0111111) begin
                    n_err++; $display("FAIL rst_mid_seg seg=%b expected 0111111", seg);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        int unsigned lead;
        for (int it = 0; it < 6; it++) begin
            en = 0; load = 0; lz_supp = 1'($urandom);
            tick();
            en = 1;
            for (int i = 0; i < 300; i++) begin
                load = ($urandom_range(0, 5) == 0);
                lead = $urandom_range(0, 4);
                v = 16'($urandom) & (16'hFFFF >> (4 * lead));
                bcd_in = v;
                dp_in = 4'($urandom);
                if ($urandom_range(0, 60) == 0) en = 0;
                tick();
                en = 1;
                n_vec++;
                if ({an, dp, frame_done} !== {exp_an, exp_dp, exp_fd}) begin
                    n_err++;
                    $display("FAIL random_model it=%0d p=%0d an/dp/fd=%b/%b/%b expected %b/%b/%b", it, m_p, an, dp, frame_done, exp_an, exp_dp, exp_fd);
                end
                if (exp_lit) begin
                    n_vec++;
                    if (seg !== exp_seg) begin
                        n_err++; $display("FAIL random_seg it=%0d p=%0d seg=%b expected %b", it, m_p, seg, exp_seg);
                    end
                end
            end
        end
        load = 0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_scan = 0; m_p = 0;
        m_shadow = '0; m_active = '0; m_shadow_dp = '0; m_active_dp = '0;
        rst = 1; en = 0; load = 0; bcd_in = '0; dp_in = '0; lz_supp = 0;
        test_reset();
        test_digit_order();
        test_lz();
        test_midframe_load();
        test_en_drop();
        test_dp();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
